// File: rtl/shift_reg_pkg.sv
// shift_reg_pkg: mode and direction types shared by the JK universal shift register.
package shift_reg_pkg;
  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHR  = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_LOAD = 2'b11
  } shift_mode_t;
  typedef enum logic {
    DIR_RIGHT = 1'b0,
    DIR_LEFT  = 1'b1
  } shift_dir_t;
endpackage

// File: rtl/jk_ff_sync.sv
// jk_ff_sync: JK flip-flop with synchronous active-high reset to a per-bit value.
module jk_ff_sync (
  input  logic clk,
  input  logic rst,
  input  logic rst_val,
  input  logic j,
  input  logic k,
  output logic q
);
  always_ff @(posedge clk)
    if (rst) q <= rst_val;
    else     q <= j ? (k ? ~q : 1'b1) : (k ? 1'b0 : q);
endmodule

// File: rtl/universal_shift_register_jk.sv
// universal_shift_register_jk: hold/shift/load register of JK cells with a frame counter.
module universal_shift_register_jk
  import shift_reg_pkg::*;
#(
  parameter int               WIDTH       = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [1:0]                 mode,
  input  logic                       serial_in_msb,
  input  logic                       serial_in_lsb,
  input  logic [WIDTH-1:0]           parallel_in,
  output logic [WIDTH-1:0]           q,
  output logic                       serial_out_lsb,
  output logic                       serial_out_msb,
  output logic [$clog2(WIDTH+1)-1:0] shift_cnt,
  output logic                       frame_done
);
  localparam int CW = $clog2(WIDTH + 1);
  shift_mode_t      m;
  shift_dir_t       last_dir, dir_now;
  logic             active, shift, wrap;
  logic [WIDTH-1:0] d, j, k;
  logic [CW-1:0]    cnt_inc;
  assign m              = shift_mode_t'(mode);
  assign active         = en && (m != MODE_HOLD);
  assign shift          = active && (m != MODE_LOAD);
  assign dir_now        = (m == MODE_SHL) ? DIR_LEFT : DIR_RIGHT;
  assign serial_out_lsb = q[0];
  assign serial_out_msb = q[WIDTH-1];
  always_comb begin
    d = (m == MODE_SHR) ? {serial_in_msb, q[WIDTH-1:1]} :
        (m == MODE_SHL) ? {q[WIDTH-2:0], serial_in_lsb} : parallel_in;
    j = active ? d : '0;
    k = active ? ~d : '0;
    cnt_inc = ((dir_now == last_dir) ? shift_cnt : '0) + CW'(1);
    wrap = (cnt_inc == CW'(WIDTH));
  end
  // Each cell is either forced to d (J=d, K=~d) or held (J=K=0); toggle never occurs.
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    jk_ff_sync u_cell (
      .clk     (clk),
      .rst     (rst),
      .rst_val (RESET_VALUE[i]),
      .j       (j[i]),
      .k       (k[i]),
      .q       (q[i])
    );
  end
  always_ff @(posedge clk)
    if (rst) begin
      shift_cnt  <= '0;
      frame_done <= 1'b0;
      last_dir   <= DIR_RIGHT;
    end else begin
      frame_done <= shift && wrap;
      if (active && m == MODE_LOAD) shift_cnt <= '0;
      else if (shift) begin
        shift_cnt <= wrap ? '0 : cnt_inc;
        last_dir  <= dir_now;
      end
    end
endmodule

// File: tb/tb_universal_shift_register_jk.sv
// tb_universal_shift_register_jk: scoreboard bench with a run-length reference model.
module tb_universal_shift_register_jk;
  localparam int W = 4;
  typedef struct {
    logic [W-1:0] q;
    int           cnt;
    logic         fd;
  } exp_t;
  logic         clk = 0, rst = 1, en = 0, serial_in_msb = 0, serial_in_lsb = 0;
  logic [1:0]   mode = 0;
  logic [W-1:0] parallel_in = 0, q;
  logic         serial_out_lsb, serial_out_msb, frame_done;
  logic [2:0]   shift_cnt;
  exp_t         sb[$];
  int           checks = 0, errors = 0;
  int           m_q = 0, m_run = 0, m_dir = 0;
  universal_shift_register_jk #(.WIDTH(W), .RESET_VALUE('0)) dut (
    .clk            (clk),
    .rst            (rst),
    .en             (en),
    .mode           (mode),
    .serial_in_msb  (serial_in_msb),
    .serial_in_lsb  (serial_in_lsb),
    .parallel_in    (parallel_in),
    .q              (q),
    .serial_out_lsb (serial_out_lsb),
    .serial_out_msb (serial_out_msb),
    .shift_cnt      (shift_cnt),
    .frame_done     (frame_done)
  );
  always #5 clk = ~clk;
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  // Reference: q as an integer, counter as the length of the current same-direction run.
  task automatic step(input logic r, input logic e, input logic [1:0] md,
                      input logic smsb, input logic slsb, input logic [W-1:0] pin);
    exp_t x;
    int   dr;
    @(negedge clk);
    rst = r; en = e; mode = md; serial_in_msb = smsb; serial_in_lsb = slsb; parallel_in = pin;
    x.fd = 0;
    if (r) begin
      m_q = 0; m_run = 0; m_dir = 0;
    end else if (e && md != 0) begin
      if (md == 3) begin
        m_q = int'(pin); m_run = 0;
      end else begin
        dr = (md == 2) ? 1 : 0;
        m_q = (md == 1) ? (int'(smsb) * (1 << (W - 1)) + m_q / 2) : ((m_q * 2 + int'(slsb)) % (1 << W));
        m_run = (dr == m_dir) ? m_run + 1 : 1;
        m_dir = dr;
        if (m_run == W) begin
          x.fd = 1; m_run = 0;
        end
      end
    end
    x.q = W'(m_q);
    x.cnt = m_run;
    sb.push_back(x);
  endtask
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("q", 32'(q), 32'(e.q));
        check("shift_cnt", 32'(shift_cnt), 32'(e.cnt));
        check("frame_done", 32'(frame_done), 32'(e.fd));
        check("serial_out_lsb", 32'(serial_out_lsb), 32'(e.q[0]));
        check("serial_out_msb", 32'(serial_out_msb), 32'(e.q[W-1]));
      end
    end
  end
  initial begin
    step(1, 0, 0, 0, 0, 0);
    step(1, 1, 1, 1, 1, 4'hF);
    step(0, 1, 1, 1, 0, 0); step(0, 1, 1, 0, 0, 0); step(0, 1, 1, 1, 0, 0); step(0, 1, 1, 1, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 2, 0, 1, 0); step(0, 1, 2, 0, 0, 0); step(0, 1, 2, 0, 1, 0); step(0, 1, 2, 0, 1, 0);
    step(0, 1, 3, 0, 0, 4'b1001); step(0, 1, 2, 0, 0, 0); step(0, 1, 2, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 1, 1, 0, 0); step(0, 1, 1, 0, 0, 0);
    step(0, 1, 2, 0, 1, 0); step(0, 1, 2, 0, 1, 0); step(0, 1, 2, 0, 0, 0); step(0, 1, 2, 0, 1, 0);
    step(0, 1, 1, 1, 0, 0); step(0, 1, 1, 1, 0, 0); step(0, 1, 1, 1, 0, 0);
    step(1, 1, 1, 1, 0, 0);
    step(0, 1, 1, 1, 0, 0); step(0, 1, 1, 1, 0, 0); step(0, 1, 1, 1, 0, 0); step(0, 1, 1, 1, 0, 0);
    step(0, 1, 1, 0, 0, 0); step(0, 1, 1, 1, 0, 0);
    step(0, 0, 1, 1, 1, 0); step(0, 0, 1, 1, 1, 0); step(0, 0, 1, 1, 1, 0);
    step(0, 1, 1, 1, 0, 0); step(0, 1, 1, 0, 0, 0);
    step(0, 1, 0, 1, 1, 4'hA);
    step(0, 1, 1, 1, 0, 0); step(0, 1, 1, 1, 0, 0); step(0, 1, 1, 1, 0, 0);
    step(0, 1, 3, 0, 0, 4'h6);
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 29) == 0, $urandom_range(0, 3) != 0, 2'($urandom),
           1'($urandom), 1'($urandom), W'($urandom));
    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
